// File: rtl/rank_insert_arbiter.sv
// -----------------------------------------------------------------------------
// rank_insert_arbiter
//
// Purpose:
//   Shares the single insert interface of a WRR rank-computation module between
//   NUM_PORTS ingress requesters using round-robin arbitration. It also owns the
//   per-flow weight table, so the weight sent to the rank module comes from
//   that table and not from the requesters. The winning request is registered
//   for one cycle, and the rank module's insert port is driven from that
//   register (grant at t, insert at t+1).
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   in_valid      per-port request valid
//   in_ready      per-port accept (combinational, one-hot or zero)
//   in_flowID     packed flowIDs, port p at [p*FLOW_ID_WIDTH +: FLOW_ID_WIDTH]
//   in_meta       packed metadata, same packing
//   cfg_wr_en     weight table write strobe
//   cfg_flowID    weight table index to write
//   cfg_weight    weight to write (0 is stored as 1)
//   rank_busy     rank module nearly-full; no grants while high
//   rank_insert   one-cycle insert pulse to the rank module
//   rank_flowID   flowID for the insert
//   rank_weight   weight looked up for the insert
//   rank_meta     metadata for the insert
//   drop_cnt      saturating count of requests dropped for an invalid flowID
// -----------------------------------------------------------------------------
module rank_insert_arbiter #(
    parameter int NUM_PORTS         = 4,
    parameter int FLOW_ID_WIDTH     = 16,
    parameter int FLOW_WEIGHT_WIDTH = 8,
    parameter int MAX_NUM_FLOWS     = 4,
    parameter int META_WIDTH        = 16,
    parameter int DROP_CNT_WIDTH    = 16
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NUM_PORTS-1:0]                 in_valid,
    output logic [NUM_PORTS-1:0]                 in_ready,
    input  logic [NUM_PORTS*FLOW_ID_WIDTH-1:0]   in_flowID,
    input  logic [NUM_PORTS*META_WIDTH-1:0]      in_meta,
    input  logic                                 cfg_wr_en,
    input  logic [FLOW_ID_WIDTH-1:0]             cfg_flowID,
    input  logic [FLOW_WEIGHT_WIDTH-1:0]         cfg_weight,
    input  logic                                 rank_busy,
    output logic                                 rank_insert,
    output logic [FLOW_ID_WIDTH-1:0]             rank_flowID,
    output logic [FLOW_WEIGHT_WIDTH-1:0]         rank_weight,
    output logic [META_WIDTH-1:0]                rank_meta,
    output logic [DROP_CNT_WIDTH-1:0]            drop_cnt
);

    localparam int PTR_W = $clog2(NUM_PORTS);
    localparam int TBL_W = (MAX_NUM_FLOWS > 1) ? $clog2(MAX_NUM_FLOWS) : 1;
    // One extra bit so MAX_NUM_FLOWS == 2**FLOW_ID_WIDTH still compares correctly.
    localparam logic [FLOW_ID_WIDTH:0]         MAX_FLOWS_EXT = (FLOW_ID_WIDTH+1)'(MAX_NUM_FLOWS);
    localparam logic [FLOW_WEIGHT_WIDTH-1:0]   WEIGHT_ONE    = FLOW_WEIGHT_WIDTH'(1);
    localparam logic [PTR_W:0]                 PORTS_EXT     = (PTR_W+1)'(NUM_PORTS);
    localparam logic [PTR_W-1:0]               LAST_PORT     = PTR_W'(NUM_PORTS-1);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [PTR_W-1:0]             r_ptr;
    logic [FLOW_WEIGHT_WIDTH-1:0] r_table [MAX_NUM_FLOWS];
    logic                         r_insert;
    logic [FLOW_ID_WIDTH-1:0]     r_flowID;
    logic [FLOW_WEIGHT_WIDTH-1:0] r_weight;
    logic [META_WIDTH-1:0]        r_meta;
    logic [DROP_CNT_WIDTH-1:0]    r_drop_cnt;

    // -------------------------------------------------------------------------
    // Combinational
    // -------------------------------------------------------------------------
    logic [FLOW_ID_WIDTH-1:0]     w_flow_arr [NUM_PORTS];
    logic [META_WIDTH-1:0]        w_meta_arr [NUM_PORTS];
    logic [PTR_W:0]               w_scan;
    logic                         w_found;
    logic [PTR_W-1:0]             w_gnt_idx;
    logic                         w_grant;
    logic [FLOW_ID_WIDTH-1:0]     w_sel_flow;
    logic [META_WIDTH-1:0]        w_sel_meta;
    logic                         w_flow_ok;
    logic [TBL_W-1:0]             w_tbl_idx;
    logic [FLOW_WEIGHT_WIDTH-1:0] w_sel_weight;
    logic                         w_accept;
    logic                         w_drop;
    logic [FLOW_WEIGHT_WIDTH-1:0] w_cfg_weight;

    // Unpack the per-port buses and build the one-hot ready vector.
    generate
        for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
            assign w_flow_arr[gi] = in_flowID[gi*FLOW_ID_WIDTH +: FLOW_ID_WIDTH];
            assign w_meta_arr[gi] = in_meta[gi*META_WIDTH +: META_WIDTH];
            assign in_ready[gi]   = w_grant && (w_gnt_idx == PTR_W'(gi));
        end
    endgenerate

    // Round-robin scan starting at r_ptr; first valid port wins. ptr and k are
    // both < NUM_PORTS, so a single conditional subtraction wraps the index.
    always_comb begin
        w_found   = 1'b0;
        w_gnt_idx = '0;
        w_scan    = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            w_scan = {1'b0, r_ptr} + (PTR_W+1)'(k);
            if (w_scan >= PORTS_EXT) begin
                w_scan = w_scan - PORTS_EXT;
            end
            if (!w_found && in_valid[w_scan[PTR_W-1:0]]) begin
                w_found   = 1'b1;
                w_gnt_idx = w_scan[PTR_W-1:0];
            end
        end
    end

    // Reset also masks the grant so nothing is accepted while rst is high.
    assign w_grant    = w_found && !rank_busy && !rst;
    assign w_sel_flow = w_flow_arr[w_gnt_idx];
    assign w_sel_meta = w_meta_arr[w_gnt_idx];

    // Full-width range check: high flowID bits must not alias into the table.
    assign w_flow_ok    = ({1'b0, w_sel_flow} < MAX_FLOWS_EXT);
    assign w_tbl_idx    = w_sel_flow[TBL_W-1:0];
    // Table read happens before this cycle's config write lands, so a grant
    // coinciding with a write to the same flow sees the old weight.
    assign w_sel_weight = w_flow_ok ? r_table[w_tbl_idx] : WEIGHT_ONE;

    assign w_accept = w_grant && w_flow_ok;
    assign w_drop   = w_grant && !w_flow_ok;

    // Zero weight would starve a flow in the WRR; clamp to 1.
    assign w_cfg_weight = (cfg_weight == '0) ? WEIGHT_ONE : cfg_weight;

    // -------------------------------------------------------------------------
    // Round-robin pointer
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (w_grant) begin
            r_ptr <= (w_gnt_idx == LAST_PORT) ? '0 : (w_gnt_idx + PTR_W'(1));
        end
    end

    // -------------------------------------------------------------------------
    // Weight table (flops: needs reset-to-1 and a same-cycle read)
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < MAX_NUM_FLOWS; i++) begin
                r_table[i] <= WEIGHT_ONE;
            end
        end else if (cfg_wr_en) begin
            // Full-width match; out-of-range indices hit no entry.
            for (int i = 0; i < MAX_NUM_FLOWS; i++) begin
                if (cfg_flowID == FLOW_ID_WIDTH'(i)) begin
                    r_table[i] <= w_cfg_weight;
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Insert register; data outputs hold when nothing is issued
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_insert <= 1'b0;
            r_flowID <= '0;
            r_weight <= '0;
            r_meta   <= '0;
        end else begin
            r_insert <= w_accept;
            if (w_accept) begin
                r_flowID <= w_sel_flow;
                r_weight <= w_sel_weight;
                r_meta   <= w_sel_meta;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_drop_cnt <= '0;
        end else if (w_drop && (r_drop_cnt != '1)) begin
            r_drop_cnt <= r_drop_cnt + DROP_CNT_WIDTH'(1);
        end
    end

    // Gating with rst kills an insert already registered when reset arrives.
    assign rank_insert = r_insert && !rst;
    assign rank_flowID = r_flowID;
    assign rank_weight = r_weight;
    assign rank_meta   = r_meta;
    assign drop_cnt    = r_drop_cnt;

endmodule

// File: tb/tb_rank_insert_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rank_insert_arbiter
//
// Directed testbench for rank_insert_arbiter (default parameters: 4 ports,
// 16-bit flowID/meta, 8-bit weight, 4 flows). Inputs change 1 ns after a
// rising edge; outputs are checked 1-2 ns after the edge.
// -----------------------------------------------------------------------------
module tb_rank_insert_arbiter;

    localparam int N   = 4;
    localparam int FW  = 16;
    localparam int WW  = 8;
    localparam int MW  = 16;
    localparam int DW  = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      in_valid;
    logic [N-1:0]      in_ready;
    logic [N*FW-1:0]   in_flowID;
    logic [N*MW-1:0]   in_meta;
    logic              cfg_wr_en;
    logic [FW-1:0]     cfg_flowID;
    logic [WW-1:0]     cfg_weight;
    logic              rank_busy;
    logic              rank_insert;
    logic [FW-1:0]     rank_flowID;
    logic [WW-1:0]     rank_weight;
    logic [MW-1:0]     rank_meta;
    logic [DW-1:0]     drop_cnt;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    rank_insert_arbiter #(
        .NUM_PORTS(N), .FLOW_ID_WIDTH(FW), .FLOW_WEIGHT_WIDTH(WW),
        .MAX_NUM_FLOWS(4), .META_WIDTH(MW), .DROP_CNT_WIDTH(DW)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_flowID(in_flowID), .in_meta(in_meta),
        .cfg_wr_en(cfg_wr_en), .cfg_flowID(cfg_flowID), .cfg_weight(cfg_weight),
        .rank_busy(rank_busy), .rank_insert(rank_insert),
        .rank_flowID(rank_flowID), .rank_weight(rank_weight),
        .rank_meta(rank_meta), .drop_cnt(drop_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] pack4(input logic [15:0] p3, input logic [15:0] p2,
                                          input logic [15:0] p1, input logic [15:0] p0);
        return {p3, p2, p1, p0};
    endfunction

    task automatic chk_ins(input string tag, input int flow, input int weight, input int meta);
        chk({tag, "_insert"}, 32'(rank_insert), 32'd1);
        chk({tag, "_flowID"}, 32'(rank_flowID), 32'(flow));
        chk({tag, "_weight"}, 32'(rank_weight), 32'(weight));
        if (meta >= 0) chk({tag, "_meta"}, 32'(rank_meta), 32'(meta));
        $display("insert %s: flowID=%0d weight=%0d meta=0x%0h", tag, rank_flowID, rank_weight, rank_meta);
    endtask

    initial begin
        rst        = 1'b1;
        in_valid   = '0;
        in_flowID  = '0;
        in_meta    = '0;
        cfg_wr_en  = 1'b0;
        cfg_flowID = '0;
        cfg_weight = '0;
        rank_busy  = 1'b0;

        // ---------------- reset ----------------
        repeat (3) tick();
        chk("rst_ready", 32'(in_ready), 32'd0);
        chk("rst_insert", 32'(rank_insert), 32'd0);
        rst = 1'b0;
        #1;
        chk("rst_flowID", 32'(rank_flowID), 32'd0);
        chk("rst_weight", 32'(rank_weight), 32'd0);
        chk("rst_meta", 32'(rank_meta), 32'd0);
        chk("rst_drop", 32'(drop_cnt), 32'd0);

        // ---------------- all ports valid: 0,1,2,3,0,1,2,3 ----------------
        in_valid  = 4'hF;
        in_flowID = pack4(16'd3, 16'd2, 16'd1, 16'd0);
        in_meta   = pack4(16'hA3, 16'hA2, 16'hA1, 16'hA0);
        #1;
        for (int i = 0; i < 8; i++) begin
            chk("rr_ready", 32'(in_ready), 32'(1 << (i % 4)));
            tick();
            chk_ins("rr", i % 4, 1, 'hA0 + (i % 4));
        end
        in_valid = '0;
        #1;
        chk("idle_ready", 32'(in_ready), 32'd0);
        tick();
        chk("idle_insert", 32'(rank_insert), 32'd0);
        chk("hold_flowID", 32'(rank_flowID), 32'd3);
        chk("hold_meta", 32'(rank_meta), 32'hA3);

        // ---------------- ports 1 and 3, ptr moved to 2 ----------------
        in_valid = 4'b0010;                 // grant port 1 -> ptr=2
        #1;
        chk("p1_ready", 32'(in_ready), 32'b0010);
        tick();
        in_valid = 4'b1010;
        #1;
        chk("p13_ready_a", 32'(in_ready), 32'b1000);
        tick();
        chk_ins("p13_a", 3, 1, 'hA3);
        chk("p13_ready_b", 32'(in_ready), 32'b0010);
        tick();
        chk_ins("p13_b", 1, 1, 'hA1);
        chk("p13_ready_c", 32'(in_ready), 32'b1000);
        tick();
        chk_ins("p13_c", 3, 1, 'hA3);
        in_valid = '0;                      // ptr=0
        tick();

        // ---------------- weight configuration ----------------
        cfg_wr_en = 1'b1; cfg_flowID = 16'd2; cfg_weight = 8'd5;
        tick();
        cfg_wr_en = 1'b0;
        in_flowID = pack4(16'd3, 16'd2, 16'd1, 16'd2);
        in_valid  = 4'b0001;
        #1;
        chk("cfg_ready", 32'(in_ready), 32'b0001);
        tick();
        chk_ins("cfg_w5", 2, 5, 'hA0);
        in_valid  = '0;
        cfg_wr_en = 1'b1; cfg_flowID = 16'd2; cfg_weight = 8'd0;
        tick();
        cfg_wr_en = 1'b0;
        in_valid  = 4'b0001;
        tick();
        chk_ins("cfg_w0", 2, 1, 'hA0);
        // write 9 to flow 2 while flow 2 is granted: old weight (1) used
        cfg_wr_en = 1'b1; cfg_flowID = 16'd2; cfg_weight = 8'd9;
        tick();
        chk_ins("cfg_same", 2, 1, 'hA0);
        cfg_wr_en = 1'b0;
        tick();
        chk_ins("cfg_new", 2, 9, 'hA0);
        // out-of-range index 0x0100 must not alias onto entry 0
        in_valid  = '0;
        cfg_wr_en = 1'b1; cfg_flowID = 16'h0100; cfg_weight = 8'd33;
        tick();
        cfg_wr_en = 1'b0;
        in_flowID = pack4(16'd3, 16'd2, 16'd1, 16'd0);
        in_valid  = 4'b0001;
        tick();
        chk_ins("cfg_oob", 0, 1, 'hA0);
        in_valid = '0;                      // ptr=1
        tick();

        // ---------------- rank_busy stall ----------------
        rank_busy = 1'b1;
        in_valid  = 4'hF;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("busy_ready", 32'(in_ready), 32'd0);
            tick();
            chk("busy_insert", 32'(rank_insert), 32'd0);
        end
        rank_busy = 1'b0;
        #1;
        chk("unbusy_ready", 32'(in_ready), 32'b0010);
        tick();
        chk_ins("unbusy", 1, 1, 'hA1);
        in_valid = '0;                      // ptr=2
        tick();

        // ---------------- invalid flowID on port 2 ----------------
        in_flowID = pack4(16'd3, 16'd7, 16'd1, 16'd0);
        in_valid  = 4'b1100;
        #1;
        chk("drop_cnt0", 32'(drop_cnt), 32'd0);
        chk("drop_ready", 32'(in_ready), 32'b0100);
        tick();
        chk("drop_insert", 32'(rank_insert), 32'd0);
        chk("drop_cnt1", 32'(drop_cnt), 32'd1);
        chk("drop_next_ready", 32'(in_ready), 32'b1000);
        tick();
        chk_ins("drop_next", 3, 1, 'hA3);
        in_valid = '0;                      // ptr=0
        tick();

        // ---------------- reset mid-operation ----------------
        cfg_wr_en = 1'b1; cfg_flowID = 16'd1; cfg_weight = 8'd7;
        tick();
        cfg_wr_en = 1'b0;
        in_flowID = pack4(16'd3, 16'd2, 16'd1, 16'd0);
        in_valid  = 4'b0010;
        tick();
        chk_ins("pre_rst", 1, 7, 'hA1);
        in_valid = 4'b0100;                 // grant flow 2 at t
        tick();
        rst      = 1'b1;                    // reset at t+1
        in_valid = '0;
        #1;
        chk("rst_kill_insert", 32'(rank_insert), 32'd0);
        tick();
        chk("rst2_insert", 32'(rank_insert), 32'd0);
        chk("rst2_flowID", 32'(rank_flowID), 32'd0);
        chk("rst2_weight", 32'(rank_weight), 32'd0);
        chk("rst2_meta", 32'(rank_meta), 32'd0);
        chk("rst2_drop", 32'(drop_cnt), 32'd0);
        rst = 1'b0;
        in_valid = 4'hF;
        #1;
        chk("rst2_ptr", 32'(in_ready), 32'b0001);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_ins("rst2_tbl", i, 1, 'hA0 + i);
        end
        in_valid = '0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
